// File: rtl/ctrl_pkg.sv
// Shared opcode and ALU-op encodings plus the packed EX control bundle.
// The bundle's dst field is sized for the widest supported REGW (DST_W).
package ctrl_pkg;

  localparam int DST_W = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_COM  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_JR   = 4'd13;
  localparam logic [3:0] OP_JAL  = 4'd14;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_COM = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  typedef struct packed {
    logic             wen;
    logic             alusrc;
    logic [2:0]       aluop;
    logic             memwrite;
    logic             memtoreg;
    logic             branch;
    logic             jump;
    logic             jr;
    logic             jal;
    logic [DST_W-1:0] dst;
    logic             illegal;
  } ctrl_t;

  // JAL links into the highest register of a REGW-wide file.
  function automatic logic [DST_W-1:0] link_reg(input int regw);
    return (DST_W'(1) << regw) - DST_W'(1);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: (op, rt, rd) -> EX control bundle.
// Opcodes wider than 4 bits are illegal unless the upper bits are zero.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int REGW = 4
) (
  input  logic [OPW-1:0]  op,
  input  logic [REGW-1:0] rt,
  input  logic [REGW-1:0] rd,
  output ctrl_t           ctrl,
  output logic            is_mul
);

  logic [3:0] op_lo;
  logic       op_hi_nz;

  assign op_lo = op[3:0];

  generate
    if (OPW > 4) begin : g_wide_op
      assign op_hi_nz = |op[OPW-1:4];
    end else begin : g_narrow_op
      assign op_hi_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    ctrl   = '0;
    is_mul = 1'b0;
    if (op_hi_nz) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (op_lo)
        OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL, OP_SLL, OP_SRL: begin
          ctrl.wen    = 1'b1;
          ctrl.aluop  = op_lo[2:0];
          ctrl.alusrc = (op_lo == OP_SLL) || (op_lo == OP_SRL);
          ctrl.dst    = DST_W'(rd);
          is_mul      = (op_lo == OP_MUL);
        end
        OP_ADDI, OP_LW: begin
          ctrl.wen      = 1'b1;
          ctrl.aluop    = ALU_ADD;
          ctrl.alusrc   = 1'b1;
          ctrl.memtoreg = (op_lo == OP_LW);
          ctrl.dst      = DST_W'(rt);
        end
        OP_SW: begin
          ctrl.alusrc   = 1'b1;
          ctrl.memwrite = 1'b1;
        end
        OP_BEQ: begin
          ctrl.branch = 1'b1;
          ctrl.aluop  = ALU_SUB;
        end
        OP_J: begin
          ctrl.jump = 1'b1;
        end
        OP_JR: begin
          ctrl.jr = 1'b1;
        end
        OP_JAL: begin
          ctrl.jump = 1'b1;
          ctrl.jal  = 1'b1;
          ctrl.wen  = 1'b1;
          ctrl.dst  = link_reg(REGW);
        end
        default: begin
          ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control stage: decode, load-use stall, multi-cycle MUL hold, flush bubbles.
// Optional sticky halt on illegal opcodes when CTRL_ILLEGAL_TRAP_EN is defined.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int REGW    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [OPW-1:0]  id_op,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_fire,
  output logic            ex_busy,
  output logic            ex_wen,
  output logic            ex_alusrc,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jr,
  output logic            ex_jal,
  output logic [2:0]      ex_aluop,
  output logic [REGW-1:0] ex_dst,
  output logic            illegal
);

  localparam int              CNTW     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_LAT - 1);

  ctrl_t           dec;
  logic            dec_mul;
  ctrl_t           ex_d, ex_q;
  logic            ex_valid_d, ex_valid_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            busy;
  logic            load_use;
  logic            accept;
  logic            halt;

  ctrl_decode #(
    .OPW  (OPW),
    .REGW (REGW)
  ) u_decode (
    .op     (id_op),
    .rt     (id_rt),
    .rd     (id_rd),
    .ctrl   (dec),
    .is_mul (dec_mul)
  );

  assign busy     = (cnt_q != '0);
  assign load_use = ex_valid_q & ex_q.memtoreg & (ex_q.dst != '0) &
                    ((ex_q.dst == DST_W'(id_rs)) | (ex_q.dst == DST_W'(id_rt)));
  assign id_ready = rst_n & ~busy & ~load_use & ~halt;
  assign accept   = id_valid & id_ready;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic halt_d, halt_q;

  always_comb begin
    halt_d = halt_q | (accept & dec.illegal);
    if (flush) halt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end

  assign halt    = halt_q;
  assign illegal = ex_q.illegal | halt_q;
`else
  assign halt    = 1'b0;
  assign illegal = ex_q.illegal;
`endif

  // Next EX contents: flush beats hold, hold beats accept, otherwise a bubble.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    cnt_d      = cnt_q;
    if (flush) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
      cnt_d      = '0;
    end else if (busy) begin
      cnt_d = cnt_q - CNTW'(1);
    end else if (accept) begin
      ex_d       = dec;
      ex_valid_d = 1'b1;
      cnt_d      = dec_mul ? MUL_LOAD : '0;
    end else begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
      cnt_d      = '0;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_busy     = busy;
  assign ex_fire     = ex_valid_q & ~busy;
  assign ex_wen      = ex_q.wen;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign ex_jr       = ex_q.jr;
  assign ex_jal      = ex_q.jal;
  assign ex_aluop    = ex_q.aluop;
  assign ex_dst      = ex_q.dst[REGW-1:0];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expected bundles queued on accept, compared on ex_fire.
// Trap-mode checks are compiled in when CTRL_ILLEGAL_TRAP_EN is defined.
module tb_ctrl_pipe;

  localparam int OPW     = 4;
  localparam int REGW    = 4;
  localparam int MUL_LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic            id_ready;
  logic [OPW-1:0]  id_op;
  logic [REGW-1:0] id_rs, id_rt, id_rd;
  logic            flush;
  logic            ex_valid, ex_fire, ex_busy;
  logic            ex_wen, ex_alusrc, ex_memwrite, ex_memtoreg;
  logic            ex_branch, ex_jump, ex_jr, ex_jal;
  logic [2:0]      ex_aluop;
  logic [REGW-1:0] ex_dst;
  logic            illegal;

  ctrl_pipe #(
    .OPW     (OPW),
    .REGW    (REGW),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_fire     (ex_fire),
    .ex_busy     (ex_busy),
    .ex_wen      (ex_wen),
    .ex_alusrc   (ex_alusrc),
    .ex_memwrite (ex_memwrite),
    .ex_memtoreg (ex_memtoreg),
    .ex_branch   (ex_branch),
    .ex_jump     (ex_jump),
    .ex_jr       (ex_jr),
    .ex_jal      (ex_jal),
    .ex_aluop    (ex_aluop),
    .ex_dst      (ex_dst),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            wen;
    logic            alusrc;
    logic [2:0]      aluop;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
    logic            jump;
    logic            jr;
    logic            jal;
    logic            illegal;
    logic [REGW-1:0] dst;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cycles = 0;
  int   fire_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [REGW-1:0] rt,
                                 input logic [REGW-1:0] rd);
    exp_t e;
    e = '0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        e.aluop = op[2:0]; e.wen = 1'b1; e.dst = rd;
      end
      4'd6, 4'd7: begin
        e.aluop = op[2:0]; e.wen = 1'b1; e.dst = rd; e.alusrc = 1'b1;
      end
      4'd8:  begin e.alusrc = 1'b1; e.wen = 1'b1; e.dst = rt; end
      4'd9:  begin e.alusrc = 1'b1; e.wen = 1'b1; e.dst = rt; e.memtoreg = 1'b1; end
      4'd10: begin e.alusrc = 1'b1; e.memwrite = 1'b1; end
      4'd11: begin e.branch = 1'b1; e.aluop = 3'b001; end
      4'd12: e.jump = 1'b1;
      4'd13: e.jr = 1'b1;
      4'd14: begin e.jump = 1'b1; e.jal = 1'b1; e.wen = 1'b1; e.dst = 4'hF; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] all_outs();
    return {13'b0, ex_valid, ex_fire, ex_busy, ex_wen, ex_alusrc, ex_memwrite, ex_memtoreg,
            ex_branch, ex_jump, ex_jr, ex_jal, ex_aluop, ex_dst, illegal};
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (ex_busy) busy_cycles++;
      if (ex_fire) begin
        exp_t obs;
        exp_t e;
        fire_cnt++;
        obs = {ex_wen, ex_alusrc, ex_aluop, ex_memwrite, ex_memtoreg, ex_branch,
               ex_jump, ex_jr, ex_jal, illegal, ex_dst};
        if (sb.size() == 0) begin
          chk("unexpected_fire", 32'(obs), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("ex_bundle", 32'(obs), 32'(e));
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [REGW-1:0] rs,
                       input logic [REGW-1:0] rt, input logic [REGW-1:0] rd);
    id_valid = 1'b1;
    id_op    = op;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [REGW-1:0] rs,
                       input logic [REGW-1:0] rt, input logic [REGW-1:0] rd,
                       output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    drive(op, rs, rt, rd);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (id_ready) begin
        got = 1'b1;
        sb.push_back(model(op, rt, rd));
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    id_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, w2, f0;
    exp_t junk;
    rst_n = 1'b0; flush = 1'b0;
    drive(4'd0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    chk("reset_ready", 32'(id_ready), 32'd0);
    id_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd0, 4'd1, 4'd2, 4'd3, w);
    chk("add_wait", 32'(w), 32'd0);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_aluop", 32'(ex_aluop), 32'd0);
    chk("add_wen", 32'(ex_wen), 32'd1);
    chk("add_dst", 32'(ex_dst), 32'd3);

    issue(4'd5, 4'd1, 4'd2, 4'd7, w);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_reset_outs", all_outs(), 32'd0);
    chk("midmul_reset_ready", 32'(id_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    issue(4'd9, 4'd1, 4'd5, 4'd0, w);
    drive(4'd0, 4'd5, 4'd2, 4'd6);
    #1 chk("lu_ready", 32'(id_ready), 32'd0);
    @(negedge clk);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    #1 chk("lu_ready_after", 32'(id_ready), 32'd1);
    sb.push_back(model(4'd0, 4'd2, 4'd6));
    @(negedge clk);
    id_valid = 1'b0;
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_dst", 32'(ex_dst), 32'd6);

    issue(4'd9, 4'd1, 4'd5, 4'd0, w);
    issue(4'd1, 4'd3, 4'd5, 4'd4, w);
    chk("lu_rt_wait", 32'(w), 32'd1);
    issue(4'd9, 4'd1, 4'd0, 4'd0, w);
    issue(4'd0, 4'd0, 4'd0, 4'd2, w);
    chk("lu_r0_wait", 32'(w), 32'd0);

    @(negedge clk);
    busy_cycles = 0;
    f0 = fire_cnt;
    issue(4'd5, 4'd1, 4'd2, 4'd4, w);
    issue(4'd0, 4'd4, 4'd2, 4'd5, w2);
    @(negedge clk);
    chk("mul_add_wait", 32'(w2), 32'(MUL_LAT - 1));
    chk("mul_busy_cycles", 32'(busy_cycles), 32'(MUL_LAT - 1));
    chk("mul_fire_count", 32'(fire_cnt - f0), 32'd2);

    issue(4'd5, 4'd1, 4'd2, 4'd4, w);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("mul_flush_busy", 32'(ex_busy), 32'd0);
    chk("mul_flush_valid", 32'(ex_valid), 32'd0);
    junk = sb.pop_back();

    issue(4'd11, 4'd1, 4'd2, 4'd0, w);
    chk("beq_branch", 32'(ex_branch), 32'd1);
    drive(4'd1, 4'd3, 4'd4, 4'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_branch", 32'(ex_branch), 32'd0);

    issue(4'd14, 4'd1, 4'd2, 4'd3, w);
    chk("jal_flags", {29'd0, ex_jump, ex_jal, ex_wen}, 32'h7);
    chk("jal_dst", 32'(ex_dst), 32'd15);
    issue(4'd10, 4'd1, 4'd6, 4'd9, w);
    chk("sw_flags", {30'd0, ex_memwrite, ex_wen}, 32'h2);
    chk("sw_dst", 32'(ex_dst), 32'd0);

    issue(4'd15, 4'd1, 4'd2, 4'd3, w);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_valid", 32'(ex_valid), 32'd1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    drive(4'd0, 4'd1, 4'd2, 4'd3);
    repeat (3) @(negedge clk);
    chk("trap_ready", 32'(id_ready), 32'd0);
    chk("trap_illegal", 32'(illegal), 32'd1);
    id_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("trap_cleared", 32'(illegal), 32'd0);
`else
    @(negedge clk);
    chk("ill_drop", 32'(illegal), 32'd0);
`endif
    issue(4'd0, 4'd1, 4'd2, 4'd3, w);
    chk("post_ill_wait", 32'(w), 32'd0);

    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (MUL_LAT + 3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
